// File: rtl/timer_cmp_ctrl_64.sv
// 64-bit compare timer with 8-bit prescaler, one-shot/periodic modes and
// sticky match interrupt / overrun flags behind a simple valid/ready config port.
module timer_cmp_ctrl_64 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [63:0] cfg_wdata,
    input  logic        start,
    input  logic        stop,
    input  logic        irq_ack,
    output logic        busy,
    output logic        done,
    output logic [63:0] count,
    output logic        irq,
    output logic        ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_CMP      = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_CTRL     = 2'd2;

    state_e      state_q, state_d;
    logic [63:0] count_q, count_d;
    logic [63:0] cmp_q, cmp_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  prescale_q, prescale_d;
    logic        mode_q, mode_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic        ovr_q, ovr_d;

    logic        wr_en;
    logic        tick;
    logic        match;

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case/if structure can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        presc_d    = presc_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        irq_en_d   = irq_en_q;
        irq_d      = irq_q;
        ovr_d      = ovr_q;

        wr_en = cfg_valid && (state_q != RUN);
        tick  = (presc_q == prescale_q);
        match = (state_q == RUN) && !stop && tick && (count_q == cmp_q);

        if (wr_en) begin
            case (cfg_addr)
                ADDR_CMP:      cmp_d      = cfg_wdata;
                ADDR_PRESCALE: prescale_d = cfg_wdata[7:0];
                ADDR_CTRL: begin
                    mode_d   = cfg_wdata[0];
                    irq_en_d = cfg_wdata[1];
                    ovr_d    = 1'b0;
                end
                default: ;
            endcase
        end

        // stop wins over everything and leaves count where it was
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (count_q == cmp_q) begin
                            if (mode_q) count_d = '0;
                            else        state_d = DONE;
                        end else begin
                            count_d = count_q + 64'd1;
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // a match coincident with an ack keeps irq set and is not an overrun
        if (match && irq_en_q) begin
            irq_d = 1'b1;
            if (irq_q && !irq_ack) ovr_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cmp_q      <= '0;
            presc_q    <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            presc_q    <= presc_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            ovr_q      <= ovr_d;
        end
    end

    assign cfg_ready = (state_q != RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign count     = count_q;
    assign irq       = irq_q;
    assign ovr       = ovr_q;

endmodule

// File: doc/timer_cmp_ctrl_64.md
TIMER_CMP_CTRL_64 -- requirements
Module: timer_cmp_ctrl_64

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
  clk        in   1   clock, all state on rising edge
  reset_n    in   1   reset, asynchronous, active-low
  cfg_valid  in   1   config write request
  cfg_ready  out  1   config write accepted when high with cfg_valid
  cfg_addr   in   2   0=CMP, 1=PRESCALE, 2=CTRL, 3=reserved
  cfg_wdata  in   64  write data
  start      in   1   start/restart request, level sampled each cycle
  stop       in   1   stop request, level sampled each cycle
  irq_ack    in   1   clears irq
  busy       out  1   high in RUN
  done       out  1   high in DONE
  count      out  64  current count value
  irq        out  1   sticky match interrupt
  ovr        out  1   sticky overrun flag

Function
REQ-003 SHALL hold registers: CMP[63:0]; PRESCALE[7:0] (cfg_wdata[7:0]); CTRL: mode=cfg_wdata[0] (0 one-shot, 1 periodic), irq_en=cfg_wdata[1].
REQ-004 SHALL complete a write on a clk edge with cfg_valid&&cfg_ready; addr 3 writes SHALL be accepted and discarded.
REQ-005 cfg_ready SHALL be 1 in IDLE and DONE, 0 in RUN (writes stall until RUN exits); cfg_ready SHALL depend only on state.
REQ-006 FSM states IDLE, RUN, DONE; busy=(RUN), done=(DONE), both registered state decodes.
REQ-007 IDLE/DONE + start && !stop -> RUN next edge; count<=0, prescaler<=0 on that edge.
REQ-008 Any state + stop -> IDLE next edge; count holds; stop SHALL win over start in the same cycle.
REQ-009 start in RUN SHALL be ignored.
REQ-010 In RUN the 8-bit prescaler SHALL count 0..PRESCALE; tick = (prescaler==PRESCALE); on tick prescaler<=0.
REQ-011 On tick with count!=CMP: count<=count+1 (64-bit, no saturation needed since CMP is constant in RUN).
REQ-012 On tick with count==CMP (match): periodic -> count<=0, stay RUN; one-shot -> DONE, count holds CMP.
REQ-013 Match period SHALL be exactly (CMP+1)*(PRESCALE+1) cycles from the RUN entry edge; CMP=0, PRESCALE=0 -> match every cycle.
REQ-014 On match with irq_en=1: irq<=1; if irq already 1 (and not being acked) ovr<=1.
REQ-015 irq_ack SHALL clear irq next edge; match and irq_ack in the same cycle SHALL leave irq=1 and SHALL NOT set ovr.
REQ-016 ovr SHALL be cleared only by a write to CTRL or by reset.
REQ-017 count, irq, ovr, cfg_ready, busy, done SHALL all be registered or state-only outputs (no input-to-output combinational path).

Reset
REQ-018 reset_n low SHALL immediately force: state IDLE, count=0, prescaler=0, CMP=0, PRESCALE=0, mode=0, irq_en=0, irq=0, ovr=0; thus busy=0, done=0, cfg_ready=1.
REQ-019 Reset asserted mid-RUN SHALL abort the run with no irq generated; first start after release SHALL behave as REQ-007.

Verification
REQ-020 Write CMP=3, PRESCALE=1, CTRL=0b10; pulse start -> busy 1 cycle after; count 0,0,1,1,2,2,3,3; match at 8th RUN cycle, done=1, irq=1, count=3, cfg_ready=1.
REQ-021 CMP=2, PRESCALE=0, CTRL=0b11, start, no ack -> count 0,1,2,0,1,2...; irq=1 after first match; ovr=1 after second match; write CTRL clears ovr only after stop.
REQ-022 cfg_valid asserted during RUN -> cfg_ready=0, CMP unchanged; assert stop -> IDLE next edge, write completes following edge, count held.
REQ-023 start and stop asserted together from IDLE -> stays IDLE, busy=0; start in RUN -> count not cleared.
REQ-024 Periodic run, irq_ack coincident with second match -> irq stays 1, ovr stays 0.
REQ-025 Drop reset_n asynchronously (between edges) at count=5 in RUN -> count=0, busy=0, irq=0 immediately, before the next clk edge.
